// File: rtl/rx_char_fifo_if.sv
// Handshake and status bundle between the UART-side character FIFO and its users.
interface rx_char_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 4
) ();
    logic [7:0]          i_rx_data;
    logic                i_rx_strobe;
    logic [7:0]          o_char;
    logic                o_valid;
    logic                i_ready;
    logic [DEPTH_LOG2:0] o_level;
    logic                o_overflow;
    logic                i_clear_ovf;
    logic                o_cts;
    logic [7:0]          o_tx_data;
    logic                o_tx_valid;
    logic                i_tx_ready;

    // Receiver, controller and transmitter side.
    modport master (
        output i_rx_data, i_rx_strobe, i_ready, i_clear_ovf, i_tx_ready,
        input  o_char, o_valid, o_level, o_overflow, o_cts, o_tx_data, o_tx_valid
    );

    // FIFO side.
    modport slave (
        input  i_rx_data, i_rx_strobe, i_ready, i_clear_ovf, i_tx_ready,
        output o_char, o_valid, o_level, o_overflow, o_cts, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/rx_char_fifo.sv
// First-word fall-through receive buffer with hysteretic CTS flow control.
// Optional XON/XOFF generator enabled by defining RX_CHAR_FIFO_XONXOFF_EN.
module rx_char_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned HIGH_MARK  = 12,
    parameter int unsigned LOW_MARK   = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rx_char_fifo_if.slave bus
);
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [LW-1:0] level, level_next;
    logic          full, pop, push, drop, cts_next;
    logic [7:0]    char_next;

    always_comb begin
        full        = (level == LW'(DEPTH));
        pop         = bus.o_valid & bus.i_ready;
        push        = bus.i_rx_strobe & (~full | pop);
        drop        = bus.i_rx_strobe & full & ~pop;
        level_next  = level + LW'(push) - LW'(pop);
        rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;

        // Head byte may be the one being written this cycle (empty, or last byte popped).
        if (level_next == '0)
            char_next = bus.o_char;
        else if (push && (wr_ptr == rd_ptr_next))
            char_next = bus.i_rx_data;
        else
            char_next = mem[rd_ptr_next];

        if (level_next >= LW'(HIGH_MARK))
            cts_next = 1'b0;
        else if (level_next <= LW'(LOW_MARK))
            cts_next = 1'b1;
        else
            cts_next = bus.o_cts;
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= bus.i_rx_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            bus.o_level    <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_char     <= 8'h00;
            bus.o_overflow <= 1'b0;
            bus.o_cts      <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr      <= rd_ptr_next;
            level       <= level_next;
            bus.o_level <= level_next;
            bus.o_valid <= (level_next != '0);
            bus.o_char  <= char_next;
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)
                bus.o_overflow <= 1'b1;
            else if (bus.i_clear_ovf)
                bus.o_overflow <= 1'b0;
            bus.o_cts <= cts_next;
        end
    end

`ifdef RX_CHAR_FIFO_XONXOFF_EN
    localparam logic [7:0] XOFF = 8'h13;
    localparam logic [7:0] XON  = 8'h11;

    typedef enum logic [1:0] {
        ST_GO        = 2'd0,
        ST_SEND_XOFF = 2'd1,
        ST_STOP      = 2'd2,
        ST_SEND_XON  = 2'd3
    } fc_state_t;

    fc_state_t  state, state_next;
    logic       tx_valid_next;
    logic [7:0] tx_data_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_GO;
            bus.o_tx_valid <= 1'b0;
            bus.o_tx_data  <= 8'h00;
        end else begin
            state          <= state_next;
            bus.o_tx_valid <= tx_valid_next;
            bus.o_tx_data  <= tx_data_next;
        end
    end

    // Pending control bytes are always completed before reacting to a new CTS level.
    always_comb begin
        state_next = state;
        case (state)
            ST_GO:        if (!bus.o_cts)     state_next = ST_SEND_XOFF;
            ST_SEND_XOFF: if (bus.i_tx_ready) state_next = ST_STOP;
            ST_STOP:      if (bus.o_cts)      state_next = ST_SEND_XON;
            ST_SEND_XON:  if (bus.i_tx_ready) state_next = ST_GO;
            default:                          state_next = ST_GO;
        endcase
    end

    always_comb begin
        tx_valid_next = 1'b0;
        tx_data_next  = 8'h00;
        case (state_next)
            ST_SEND_XOFF: begin
                tx_valid_next = 1'b1;
                tx_data_next  = XOFF;
            end
            ST_SEND_XON: begin
                tx_valid_next = 1'b1;
                tx_data_next  = XON;
            end
            default: ;
        endcase
    end
`else
    logic unused_tx_ready;
    assign unused_tx_ready = bus.i_tx_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_tx_valid <= 1'b0;
            bus.o_tx_data  <= 8'h00;
        end else begin
            bus.o_tx_valid <= 1'b0;
            bus.o_tx_data  <= 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_rx_char_fifo.sv
// Directed self-checking bench for rx_char_fifo (default and XON/XOFF builds).
module tb_rx_char_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    rx_char_fifo_if #(.DEPTH_LOG2(4)) bus ();

    rx_char_fifo #(.DEPTH_LOG2(4), .HIGH_MARK(12), .LOW_MARK(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        bus.i_rx_data   = d;
        bus.i_rx_strobe = 1'b1;
        tick();
        bus.i_rx_strobe = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_level"},    32'(bus.o_level),    32'd0);
        chk({tag, "_valid"},    32'(bus.o_valid),    32'd0);
        chk({tag, "_char"},     32'(bus.o_char),     32'd0);
        chk({tag, "_overflow"}, 32'(bus.o_overflow), 32'd0);
        chk({tag, "_cts"},      32'(bus.o_cts),      32'd1);
        chk({tag, "_tx_valid"}, 32'(bus.o_tx_valid), 32'd0);
        chk({tag, "_tx_data"},  32'(bus.o_tx_data),  32'd0);
    endtask

    initial begin
        bus.i_rx_data   = 8'h00;
        bus.i_rx_strobe = 1'b0;
        bus.i_ready     = 1'b0;
        bus.i_clear_ovf = 1'b0;
        bus.i_tx_ready  = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // Single byte fall-through, held while not ready, then popped.
        push_byte(8'h41);
        chk("t1_valid", 32'(bus.o_valid), 32'd1);
        chk("t1_char",  32'(bus.o_char),  32'h41);
        chk("t1_level", 32'(bus.o_level), 32'd1);
        tick();
        chk("t1_hold_char", 32'(bus.o_char), 32'h41);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk("t1_pop_valid", 32'(bus.o_valid), 32'd0);
        chk("t1_pop_level", 32'(bus.o_level), 32'd0);

        // Fill to full, watching CTS fall at 12, then overflow.
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(8'h30 + i));
            chk("t2_fill_level", 32'(bus.o_level), 32'(i + 1));
            chk("t2_fill_cts",   32'(bus.o_cts),   (i + 1 >= 12) ? 32'd0 : 32'd1);
        end
        chk("t2_no_ovf_yet", 32'(bus.o_overflow), 32'd0);
        push_byte(8'h40);
        chk("t2_ovf_level", 32'(bus.o_level),    32'd16);
        chk("t2_ovf_flag",  32'(bus.o_overflow), 32'd1);
        chk("t2_ovf_head",  32'(bus.o_char),     32'h30);
`ifndef RX_CHAR_FIFO_XONXOFF_EN
        chk("t2_tx_valid_off", 32'(bus.o_tx_valid), 32'd0);
        chk("t2_tx_data_off",  32'(bus.o_tx_data),  32'd0);
`endif

        // Drop and clear together: set wins; then a lone clear.
        bus.i_clear_ovf = 1'b1;
        push_byte(8'h42);
        chk("t2_set_wins", 32'(bus.o_overflow), 32'd1);
        tick();
        bus.i_clear_ovf = 1'b0;
        chk("t2_clear", 32'(bus.o_overflow), 32'd0);

        // Drain in order, checking CTS hysteresis on the way down.
        bus.i_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_char",  32'(bus.o_char),  32'(8'h30 + i));
            chk("t2_drain_level", 32'(bus.o_level), 32'(16 - i));
            chk("t2_drain_cts",   32'(bus.o_cts),   (16 - i <= 4) ? 32'd1 : 32'd0);
            tick();
        end
        bus.i_ready = 1'b0;
        chk("t2_empty_valid", 32'(bus.o_valid), 32'd0);
        chk("t2_empty_level", 32'(bus.o_level), 32'd0);
        chk("t2_empty_cts",   32'(bus.o_cts),   32'd1);

        // Full FIFO, push and pop together: no drop.
        for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i));
        bus.i_ready = 1'b1;
        push_byte(8'h55);
        bus.i_ready = 1'b0;
        chk("t3_level", 32'(bus.o_level),    32'd16);
        chk("t3_ovf",   32'(bus.o_overflow), 32'd0);
        chk("t3_head",  32'(bus.o_char),     32'h61);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_char", 32'(bus.o_char), (i < 15) ? 32'(8'h61 + i) : 32'h55);
            tick();
        end
        bus.i_ready = 1'b0;
        chk("t3_empty_valid", 32'(bus.o_valid), 32'd0);

        // Level 7 with CTS low (XOFF pending in the feature build), then async reset.
        for (int i = 0; i < 12; i++) push_byte(8'(i));
        bus.i_ready = 1'b1;
        repeat (5) tick();
        bus.i_ready = 1'b0;
        chk("t4_level", 32'(bus.o_level), 32'd7);
        chk("t4_cts",   32'(bus.o_cts),   32'd0);
`ifdef RX_CHAR_FIFO_XONXOFF_EN
        chk("t4_xoff_pending", 32'(bus.o_tx_valid), 32'd1);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async");
        tick();
        rst = 1'b0;
        tick();
        chk("t4_after_valid", 32'(bus.o_valid), 32'd0);

`ifdef RX_CHAR_FIFO_XONXOFF_EN
        // XOFF held under backpressure and accepted once, then a single XON.
        bus.i_tx_ready = 1'b0;
        for (int i = 0; i < 12; i++) push_byte(8'(8'h70 + i));
        chk("x_cts_low", 32'(bus.o_cts),      32'd0);
        chk("x_go",      32'(bus.o_tx_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("x_xoff_valid", 32'(bus.o_tx_valid), 32'd1);
            chk("x_xoff_data",  32'(bus.o_tx_data),  32'h13);
        end
        bus.i_tx_ready = 1'b1;
        tick();
        bus.i_tx_ready = 1'b0;
        chk("x_xoff_taken", 32'(bus.o_tx_valid), 32'd0);
        tick();
        chk("x_stop_idle", 32'(bus.o_tx_valid), 32'd0);
        bus.i_ready = 1'b1;
        repeat (8) tick();
        bus.i_ready = 1'b0;
        chk("x_level4", 32'(bus.o_level),    32'd4);
        chk("x_cts_hi", 32'(bus.o_cts),      32'd1);
        chk("x_stop",   32'(bus.o_tx_valid), 32'd0);
        tick();
        chk("x_xon_valid", 32'(bus.o_tx_valid), 32'd1);
        chk("x_xon_data",  32'(bus.o_tx_data),  32'h11);
        bus.i_tx_ready = 1'b1;
        tick();
        bus.i_tx_ready = 1'b0;
        chk("x_xon_taken", 32'(bus.o_tx_valid), 32'd0);
        tick();
        chk("x_go_idle", 32'(bus.o_tx_valid), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
